// File: rtl/ternary_neuron_seq_pkg.sv
// Shared types and constants for the sequential ternary neuron.
// Holds the FSM state encoding, the output class codes and the popcount width.
package ternary_neuron_seq_pkg;

    localparam int unsigned BEAT_W = 19;
    localparam int unsigned PC_W   = 5;

    typedef enum logic [1:0] {
        StIdle,
        StPos,
        StNeg,
        StDone
    } state_e;

    localparam logic [1:0] CLS_POS  = 2'b01;
    localparam logic [1:0] CLS_ZERO = 2'b00;
    localparam logic [1:0] CLS_NEG  = 2'b11;

endpackage

// File: rtl/ternary_neuron_seq_popcount19_core.sv
// 19-input population count, exact or approximate, selected by PC_EXACT.
// Purely combinational; the neuron shares one instance across both passes.
module popcount19_core
    import ternary_neuron_seq_pkg::*;
#(
    parameter int unsigned PC_EXACT = 0
) (
    input  logic [BEAT_W-1:0] data_i,
    output logic [PC_W-1:0]   count_o
);

    if (PC_EXACT != 0) begin : g_exact
        always_comb begin
            count_o = '0;
            for (int i = 0; i < BEAT_W; i++) begin
                count_o = count_o + PC_W'(data_i[i]);
            end
        end
    end else begin : g_approx
        // Each bit pair counts as 2 when either bit is set; bit 18 counts alone.
        always_comb begin
            count_o = PC_W'(data_i[BEAT_W-1]);
            for (int i = 0; i < (BEAT_W - 1) / 2; i++) begin
                count_o = count_o + PC_W'({data_i[2*i] | data_i[2*i+1], 1'b0});
            end
        end
    end

endmodule

// File: rtl/ternary_neuron_seq.sv
// Sequential ternary neuron: per beat, popcount of the positive then negative mask
// is accumulated; the signed difference is thresholded into a ternary class.
module ternary_neuron_seq
    import ternary_neuron_seq_pkg::*;
#(
    parameter int unsigned NWORDS   = 4,
    parameter int unsigned ACC_W    = 7,
    parameter int unsigned PC_EXACT = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BEAT_W-1:0]       in_pos,
    input  logic [BEAT_W-1:0]       in_neg,
    input  logic                    in_last,
    input  logic signed [ACC_W:0]   thr_hi,
    input  logic signed [ACC_W:0]   thr_lo,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W:0]   out_sum,
    output logic [1:0]              out_class,
    output logic                    out_err
);

    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam int unsigned CNT_W  = $clog2(NWORDS) + 1;
    localparam int unsigned WIDE_W = ACC_W + PC_W;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    state_e                    state_q, state_d;
    logic [BEAT_W-1:0]         pos_q, pos_d;
    logic [BEAT_W-1:0]         neg_q, neg_d;
    logic                      last_q, last_d;
    logic signed [SUM_W-1:0]   thr_hi_q, thr_hi_d;
    logic signed [SUM_W-1:0]   thr_lo_q, thr_lo_d;
    logic [ACC_W-1:0]          acc_pos_q, acc_pos_d;
    logic [ACC_W-1:0]          acc_neg_q, acc_neg_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [SUM_W-1:0]   sum_q, sum_d;
    logic [1:0]                class_q, class_d;
    logic                      err_q, err_d;

    logic [BEAT_W-1:0]         pc_in;
    logic [PC_W-1:0]           pc_cnt;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [PC_W-1:0]  pc);
        logic [WIDE_W-1:0] wide;
        wide = WIDE_W'(acc) + WIDE_W'(pc);
        if (wide > WIDE_W'(ACC_MAX)) begin
            return ACC_MAX;
        end
        return wide[ACC_W-1:0];
    endfunction

    // +1 wins over -1 when the thresholds overlap.
    function automatic logic [1:0] classify(input logic signed [SUM_W-1:0] s,
                                            input logic signed [SUM_W-1:0] hi,
                                            input logic signed [SUM_W-1:0] lo);
        if (s >= hi) begin
            return CLS_POS;
        end else if (s <= lo) begin
            return CLS_NEG;
        end
        return CLS_ZERO;
    endfunction

    // One popcount serves both passes; the mask follows the current state.
    assign pc_in = (state_q == StNeg) ? neg_q : pos_q;

    popcount19_core #(
        .PC_EXACT (PC_EXACT)
    ) u_popcount (
        .data_i  (pc_in),
        .count_o (pc_cnt)
    );

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        neg_d     = neg_q;
        last_d    = last_q;
        thr_hi_d  = thr_hi_q;
        thr_lo_d  = thr_lo_q;
        acc_pos_d = acc_pos_q;
        acc_neg_d = acc_neg_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        class_d   = class_q;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    pos_d   = in_pos;
                    neg_d   = in_neg;
                    last_d  = in_last;
                    state_d = StPos;
                    if (cnt_q == '0) begin
                        thr_hi_d = thr_hi;
                        thr_lo_d = thr_lo;
                    end
                end
            end
            StPos: begin
                acc_pos_d = sat_add(acc_pos_q, pc_cnt);
                state_d   = StNeg;
            end
            StNeg: begin
                acc_neg_d = sat_add(acc_neg_q, pc_cnt);
                cnt_d     = cnt_q + CNT_W'(1);
                if (last_q || (cnt_q == CNT_W'(NWORDS - 1))) begin
                    state_d = StDone;
                    sum_d   = $signed({1'b0, acc_pos_q}) - $signed({1'b0, acc_neg_d});
                    class_d = classify(sum_d, thr_hi_q, thr_lo_q);
                    err_d   = ~last_q;
                end else begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d   = StIdle;
                    acc_pos_d = '0;
                    acc_neg_d = '0;
                    cnt_d     = '0;
                    sum_d     = '0;
                    class_d   = CLS_ZERO;
                    err_d     = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pos_q     <= '0;
            neg_q     <= '0;
            last_q    <= 1'b0;
            thr_hi_q  <= '0;
            thr_lo_q  <= '0;
            acc_pos_q <= '0;
            acc_neg_q <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            class_q   <= CLS_ZERO;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            neg_q     <= neg_d;
            last_q    <= last_d;
            thr_hi_q  <= thr_hi_d;
            thr_lo_q  <= thr_lo_d;
            acc_pos_q <= acc_pos_d;
            acc_neg_q <= acc_neg_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            class_q   <= class_d;
            err_q     <= err_d;
        end
    end

    // Ready and valid decode registered state only, so out_ready never reaches in_ready.
    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_sum   = sum_q;
    assign out_class = class_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_ternary_neuron_seq.sv
// Directed bench for ternary_neuron_seq: vector table plus hand sequences for
// back-pressure, count-limit termination, mid-neuron reset and saturation.
module tb_ternary_neuron_seq;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [18:0]       in_pos;
    logic [18:0]       in_neg;
    logic              in_last;
    logic signed [7:0] thr_hi;
    logic signed [7:0] thr_lo;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_sum;
    logic [1:0]        out_class;
    logic              out_err;

    // Narrow-accumulator instance used only to reach saturation.
    logic              d2_in_valid;
    logic              d2_in_ready;
    logic [18:0]       d2_in_pos;
    logic [18:0]       d2_in_neg;
    logic              d2_in_last;
    logic signed [5:0] d2_thr_hi;
    logic signed [5:0] d2_thr_lo;
    logic              d2_out_valid;
    logic              d2_out_ready;
    logic signed [5:0] d2_out_sum;
    logic [1:0]        d2_out_class;
    logic              d2_out_err;

    int checks = 0;
    int errors = 0;

    ternary_neuron_seq #(.NWORDS(4), .ACC_W(7), .PC_EXACT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pos    (in_pos),
        .in_neg    (in_neg),
        .in_last   (in_last),
        .thr_hi    (thr_hi),
        .thr_lo    (thr_lo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_class (out_class),
        .out_err   (out_err)
    );

    ternary_neuron_seq #(.NWORDS(4), .ACC_W(5), .PC_EXACT(1)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (d2_in_valid),
        .in_ready  (d2_in_ready),
        .in_pos    (d2_in_pos),
        .in_neg    (d2_in_neg),
        .in_last   (d2_in_last),
        .thr_hi    (d2_thr_hi),
        .thr_lo    (d2_thr_lo),
        .out_valid (d2_out_valid),
        .out_ready (d2_out_ready),
        .out_sum   (d2_out_sum),
        .out_class (d2_out_class),
        .out_err   (d2_out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              nbeats;
        logic [3:0][18:0] pos;
        logic [3:0][18:0] neg;
        logic [3:0]      last;
        int              thr_hi;
        int              thr_lo;
        int              exp_sum;
        int              exp_class;
        int              exp_err;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs[NVEC];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [18:0] p, input logic [18:0] n, input logic l,
                             input logic signed [7:0] hi, input logic signed [7:0] lo);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_wait", int'(in_ready), 1);
        in_pos   = p;
        in_neg   = n;
        in_last  = l;
        thr_hi   = hi;
        thr_lo   = lo;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Latency in cycles from the accepting edge until out_valid is seen.
    task automatic wait_done(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = 99;
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic d2_beat(input logic [18:0] p, input logic [18:0] n, input logic l);
        int w = 0;
        @(negedge clk);
        while (!d2_in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("d2_in_ready_wait", int'(d2_in_ready), 1);
        d2_in_pos   = p;
        d2_in_neg   = n;
        d2_in_last  = l;
        d2_in_valid = 1'b1;
        @(posedge clk);
        #1 d2_in_valid = 1'b0;
    endtask

    task automatic d2_result(input string name, input int exp_sum, input int exp_class);
        int w = 0;
        @(negedge clk);
        while (!d2_out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({name, "_valid"}, int'(d2_out_valid), 1);
        chk({name, "_sum"}, int'(d2_out_sum), exp_sum);
        chk({name, "_class"}, int'(d2_out_class), exp_class);
        @(negedge clk);
        d2_out_ready = 1'b1;
        @(posedge clk);
        #1 d2_out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic signed [7:0] hi;
        logic signed [7:0] lo;

        vecs[0] = '{1, {19'h0, 19'h0, 19'h0, 19'h7FFFF}, {19'h0, 19'h0, 19'h0, 19'h0},
                    4'b0001, 10, -10, 19, 1, 0};
        vecs[1] = '{2, {19'h0, 19'h0, 19'h0000F, 19'h0000F}, {19'h0, 19'h0, 19'h000FF, 19'h000FF},
                    4'b0010, 3, -3, -8, 3, 0};
        vecs[2] = '{4, {19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF},
                    {19'h1, 19'h1, 19'h1, 19'h1}, 4'b0000, 100, -100, 72, 0, 1};
        vecs[3] = '{1, {19'h0, 19'h0, 19'h0, 19'h00007}, {19'h0, 19'h0, 19'h0, 19'h70000},
                    4'b0001, 0, 0, 0, 1, 0};
        vecs[4] = '{3, {19'h0, 19'h10000, 19'h000F0, 19'h00003},
                    {19'h0, 19'h00300, 19'h0, 19'h00001}, 4'b0100, 4, -2, 4, 1, 0};
        vecs[5] = '{1, {19'h0, 19'h0, 19'h0, 19'h0}, {19'h0, 19'h0, 19'h0, 19'h0001F},
                    4'b0001, 5, -5, -5, 3, 0};
        vecs[6] = '{4, {19'h1, 19'h1, 19'h1, 19'h1}, {19'h3, 19'h3, 19'h3, 19'h3},
                    4'b1000, 10, -10, -4, 0, 0};

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_pos       = '0;
        in_neg       = '0;
        in_last      = 1'b0;
        thr_hi       = '0;
        thr_lo       = '0;
        out_ready    = 1'b0;
        d2_in_valid  = 1'b0;
        d2_in_pos    = '0;
        d2_in_neg    = '0;
        d2_in_last   = 1'b0;
        d2_thr_hi    = 6'sd20;
        d2_thr_lo    = -6'sd20;
        d2_out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_out_class", int'(out_class), 0);
        chk("rst_out_err", int'(out_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Beats after the first carry misleading thresholds that must be ignored.
        for (int i = 0; i < NVEC; i++) begin
            for (int b = 0; b < vecs[i].nbeats; b++) begin
                if (b == 0) begin
                    hi = 8'(vecs[i].thr_hi);
                    lo = 8'(vecs[i].thr_lo);
                end else begin
                    hi = -8'sd64;
                    lo = 8'sd63;
                end
                send_beat(vecs[i].pos[b], vecs[i].neg[b], vecs[i].last[b], hi, lo);
            end
            wait_done(lat);
            chk($sformatf("v%0d_latency", i), lat, 3);
            chk($sformatf("v%0d_sum", i), int'(out_sum), vecs[i].exp_sum);
            chk($sformatf("v%0d_class", i), int'(out_class), vecs[i].exp_class);
            chk($sformatf("v%0d_err", i), int'(out_err), vecs[i].exp_err);
            chk($sformatf("v%0d_ready_in_done", i), int'(in_ready), 0);
            handshake();
            chk($sformatf("v%0d_valid_cleared", i), int'(out_valid), 0);
            chk($sformatf("v%0d_ready_after", i), int'(in_ready), 1);
        end

        // Count-limit termination, then back-pressure with a pending fifth beat.
        for (int b = 0; b < 4; b++) begin
            send_beat(19'h00003, 19'h0, 1'b0, 8'sd20, -8'sd20);
        end
        wait_done(lat);
        chk("lim_latency", lat, 3);
        in_pos   = 19'h7FFFF;
        in_neg   = 19'h0;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_valid", c), int'(out_valid), 1);
            chk($sformatf("hold%0d_ready", c), int'(in_ready), 0);
            chk($sformatf("hold%0d_sum", c), int'(out_sum), 8);
            chk($sformatf("hold%0d_class", c), int'(out_class), 0);
            chk($sformatf("hold%0d_err", c), int'(out_err), 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("release_valid", int'(out_valid), 0);
        chk("release_ready", int'(in_ready), 1);
        chk("release_err", int'(out_err), 0);
        send_beat(19'h00001, 19'h0, 1'b1, 8'sd1, -8'sd1);
        wait_done(lat);
        chk("fresh_latency", lat, 3);
        chk("fresh_sum", int'(out_sum), 1);
        chk("fresh_class", int'(out_class), 1);
        chk("fresh_err", int'(out_err), 0);
        handshake();

        // Reset while the second beat is in its negative pass.
        send_beat(19'h7FFFF, 19'h0, 1'b0, 8'sd5, -8'sd5);
        send_beat(19'h7FFFF, 19'h0, 1'b0, 8'sd5, -8'sd5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_ready", int'(in_ready), 1);
        chk("midrst_sum", int'(out_sum), 0);
        chk("midrst_class", int'(out_class), 0);
        chk("midrst_err", int'(out_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_ready", int'(in_ready), 1);
        send_beat(19'h00003, 19'h00001, 1'b1, 8'sd1, -8'sd1);
        wait_done(lat);
        chk("postrst_latency", lat, 3);
        chk("postrst_sum", int'(out_sum), 1);
        chk("postrst_class", int'(out_class), 1);
        handshake();

        // Saturation at 2^5-1 on the narrow instance.
        d2_beat(19'h7FFFF, 19'h7FFFF, 1'b0);
        d2_beat(19'h7FFFF, 19'h0, 1'b1);
        d2_result("satpos", 12, 0);
        d2_beat(19'h0, 19'h7FFFF, 1'b0);
        d2_beat(19'h0, 19'h7FFFF, 1'b1);
        d2_result("satneg", -31, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ternary_neuron_seq.md
TERNARY_NEURON_SEQ -- requirements
Module: ternary_neuron_seq

Interface
REQ-001 Parameter NWORDS, default 4: maximum number of 19-bit beats per neuron evaluation.
REQ-002 Parameter ACC_W, default 7: width of each unsigned accumulator; sums are ACC_W+1 bits signed.
REQ-003 Parameter PC_EXACT, default 0: 1 selects the exact popcount core, 0 selects the approximate core.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  input beat valid.
REQ-007 in_ready  out  1  block can accept a beat.
REQ-008 in_pos  in  19  activation AND positive-weight mask.
REQ-009 in_neg  in  19  activation AND negative-weight mask.
REQ-010 in_last  in  1  final beat of the neuron.
REQ-011 thr_hi  in  ACC_W+1  signed upper threshold.
REQ-012 thr_lo  in  ACC_W+1  signed lower threshold.
REQ-013 out_valid  out  1  result valid.
REQ-014 out_ready  in  1  consumer accepts the result.
REQ-015 out_sum  out  ACC_W+1  signed sum, acc_pos - acc_neg.
REQ-016 out_class  out  2  ternary class: 01 = +1, 11 = -1, 00 = 0.
REQ-017 out_err  out  1  neuron was force-terminated at NWORDS beats without in_last.

Function
REQ-018 The block SHALL time-share one combinational 19-input popcount instance for both the positive and negative passes.
REQ-019 FSM states SHALL be IDLE, POS, NEG and DONE.
REQ-020 IDLE: in_ready=1; in_valid SHALL capture in_pos, in_neg and in_last into beat registers and move to POS.
REQ-021 On the first beat of a neuron (beat count 0), thr_hi and thr_lo SHALL be sampled and held until DONE is left.
REQ-022 POS: popcount(in_pos_reg) SHALL be added to acc_pos; next state NEG.
REQ-023 NEG: popcount(in_neg_reg) SHALL be added to acc_neg; beat count +1; next state DONE if last_reg or beat count == NWORDS-1, else IDLE.
REQ-024 Throughput SHALL be one beat per 3 cycles; out_valid SHALL rise on the cycle after NEG of the final beat.
REQ-025 in_ready SHALL be 0 in POS, NEG and DONE; no beat is captured in those states.
REQ-026 Accumulators SHALL saturate at 2^ACC_W-1 and never wrap.
REQ-027 Class: out_sum >= thr_hi gives +1; otherwise out_sum <= thr_lo gives -1; otherwise 0. +1 SHALL take priority when the thresholds overlap.
REQ-028 out_err SHALL be 1 when the final beat had last_reg=0 (count limit reached); the neuron is still classified normally.
REQ-029 DONE: out_valid=1, and outputs SHALL be stable until out_ready. out_valid&&out_ready SHALL clear accumulators, beat count and err, and return to IDLE.
REQ-030 in_valid in DONE SHALL be ignored, with no combinational path from out_ready to in_ready.

Reset
REQ-031 rst_n low SHALL immediately force IDLE and clear: out_valid=0, out_sum=0, out_class=00, out_err=0, accumulators=0, beat count=0, beat registers=0.
REQ-032 Reset mid-neuron SHALL discard the partial neuron; in_ready SHALL be 1 in the first cycle after release.

Structure
REQ-033 A shared package SHALL hold the state enum, the class encodings (CLS_POS, CLS_ZERO, CLS_NEG) and the popcount width constant PC_W=5.
REQ-034 The popcount SHALL be a single sub-module, popcount19_core, selected by PC_EXACT; the rest is flat RTL.

Verification (PC_EXACT=1, ACC_W=7, NWORDS=4)
REQ-035 Single beat pos=all-ones, neg=0, last=1, thr_hi=10, thr_lo=-10 -> out_valid 3 cycles after acceptance, out_sum=19, class=01, err=0.
REQ-036 Two beats pos=0x0000F, neg=0x000FF (last on beat 2), thr_hi=3, thr_lo=-3 -> out_sum=-8, class=11.
REQ-037 Four beats with in_last=0 throughout -> DONE after beat 4, err=1, and the fifth in_valid is held off (in_ready=0).
REQ-038 Hold out_ready=0 for 5 cycles in DONE -> outputs stable; on release, accumulators clear and the next neuron starts from 0.
REQ-039 thr_hi=0, thr_lo=0, equal pos/neg counts (sum=0) -> class=01 (priority rule).
REQ-040 Assert rst_n low during NEG of beat 2 -> all outputs 0 immediately; the next neuron's result excludes pre-reset beats.
